// File: rtl/mfp_irq_ctrl.sv
// MC68901-style 16-channel interrupt controller: pending/enable/mask/in-service
// registers, fixed priority (ch15 highest), registered IRQ_N and vector on acknowledge.
module mfp_irq_ctrl #(
    parameter int          NCH      = 16,
    parameter logic [7:0]  SPUR_VEC = 8'h18
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic [NCH-1:0] IRQ_SRC,
    input  logic           REG_WE,
    input  logic [3:0]     REG_SEL,
    input  logic [7:0]     DAT_I,
    output logic [7:0]     DAT_O,
    input  logic           IACK,
    output logic           IRQ_N,
    output logic [7:0]     VEC_O,
    output logic           VEC_VALID
);

    typedef enum logic [3:0] {
        SEL_IERA = 4'd0, SEL_IERB = 4'd1, SEL_IPRA = 4'd2, SEL_IPRB = 4'd3,
        SEL_ISRA = 4'd4, SEL_ISRB = 4'd5, SEL_IMRA = 4'd6, SEL_IMRB = 4'd7,
        SEL_VR   = 4'd8
    } reg_sel_e;

    logic [NCH-1:0] ier, ipr, isr, imr;
    logic [7:0]     vr;

    logic [NCH-1:0] ier_nxt, ipr_nxt, isr_nxt, imr_nxt;
    logic [7:0]     vr_nxt;
    logic [NCH-1:0] cand, ier_drop, top_mask;
    logic [3:0]     top, isr_top;
    logic           req, ack_hit, s_mode;

    function automatic logic [3:0] msb_idx(input logic [NCH-1:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < NCH; i++) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    // Priority resolution on current (pre-write) state.
    assign cand     = ipr & imr;
    assign top      = msb_idx(cand);
    assign isr_top  = msb_idx(isr);
    assign req      = (cand != '0) && ((isr == '0) || (top > isr_top));
    assign ack_hit  = IACK && req;
    assign s_mode   = vr[3];
    assign top_mask = NCH'(1) << top;

    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        ier_nxt = ier;
        imr_nxt = imr;
        vr_nxt  = vr;
        ipr_nxt = ipr;
        isr_nxt = isr;

        if (REG_WE) begin
            case (REG_SEL)
                SEL_IERA: ier_nxt[15:8] = DAT_I;
                SEL_IERB: ier_nxt[7:0]  = DAT_I;
                SEL_IPRA: ipr_nxt       = ipr_nxt & {DAT_I, 8'hFF};
                SEL_IPRB: ipr_nxt       = ipr_nxt & {8'hFF, DAT_I};
                SEL_ISRA: isr_nxt       = isr_nxt & {DAT_I, 8'hFF};
                SEL_ISRB: isr_nxt       = isr_nxt & {8'hFF, DAT_I};
                SEL_IMRA: imr_nxt[15:8] = DAT_I;
                SEL_IMRB: imr_nxt[7:0]  = DAT_I;
                SEL_VR:   vr_nxt        = DAT_I;
                default:  ;
            endcase
        end

        // Clears first, then event set (beats write/ack clears), then disable clear (beats set).
        ier_drop = ier & ~ier_nxt;
        if (ack_hit) ipr_nxt = ipr_nxt & ~top_mask;
        ipr_nxt = ipr_nxt | (IRQ_SRC & ier);
        ipr_nxt = ipr_nxt & ~ier_drop;

        if (ack_hit && s_mode) isr_nxt = isr_nxt | top_mask;
        if (REG_WE && (REG_SEL == SEL_VR) && !DAT_I[3] && s_mode) isr_nxt = '0;
    end

    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (RST) begin
            ier       <= '0;
            ipr       <= '0;
            isr       <= '0;
            imr       <= '0;
            vr        <= '0;
            IRQ_N     <= 1'b1;
            VEC_O     <= 8'h00;
            VEC_VALID <= 1'b0;
        end else begin
            ier       <= ier_nxt;
            ipr       <= ipr_nxt;
            isr       <= isr_nxt;
            imr       <= imr_nxt;
            vr        <= vr_nxt;
            IRQ_N     <= ~req;
            VEC_VALID <= IACK;
            if (IACK) VEC_O <= req ? {vr[7:4], top} : SPUR_VEC;
        end
    end

    always_comb begin
        DAT_O = 8'h00;
        case (REG_SEL)
            SEL_IERA: DAT_O = ier[15:8];
            SEL_IERB: DAT_O = ier[7:0];
            SEL_IPRA: DAT_O = ipr[15:8];
            SEL_IPRB: DAT_O = ipr[7:0];
            SEL_ISRA: DAT_O = isr[15:8];
            SEL_ISRB: DAT_O = isr[7:0];
            SEL_IMRA: DAT_O = imr[15:8];
            SEL_IMRB: DAT_O = imr[7:0];
            SEL_VR:   DAT_O = vr;
            default:  DAT_O = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_mfp_irq_ctrl.sv
// Directed bench for mfp_irq_ctrl; expected vectors go to a queue that a
// negedge monitor drains whenever VEC_VALID is seen.
module tb_mfp_irq_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic [15:0] IRQ_SRC;
    logic        REG_WE;
    logic [3:0]  REG_SEL;
    logic [7:0]  DAT_I;
    logic [7:0]  DAT_O;
    logic        IACK;
    logic        IRQ_N;
    logic [7:0]  VEC_O;
    logic        VEC_VALID;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];

    mfp_irq_ctrl dut (
        .CLK(CLK), .RST(RST), .IRQ_SRC(IRQ_SRC), .REG_WE(REG_WE),
        .REG_SEL(REG_SEL), .DAT_I(DAT_I), .DAT_O(DAT_O), .IACK(IACK),
        .IRQ_N(IRQ_N), .VEC_O(VEC_O), .VEC_VALID(VEC_VALID)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every vector the DUT presents must match the oldest expectation.
    always @(negedge CLK) begin
        if (VEC_VALID === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_vec: got %h expected no VEC_VALID", VEC_O);
            end else begin
                check("vec", VEC_O, exp_q.pop_front());
            end
        end
    end

    // All tasks start and end on a negedge.
    task automatic cycle();
        @(negedge CLK);
    endtask

    task automatic wr(input logic [3:0] sel, input logic [7:0] d);
        REG_WE = 1'b1; REG_SEL = sel; DAT_I = d;
        @(negedge CLK);
        REG_WE = 1'b0;
    endtask

    task automatic rd(input string name, input logic [3:0] sel, input logic [7:0] exp);
        REG_SEL = sel;
        #1;
        check(name, DAT_O, exp);
    endtask

    task automatic pulse(input logic [15:0] src);
        IRQ_SRC = src;
        @(negedge CLK);
        IRQ_SRC = '0;
    endtask

    task automatic ack(input logic [7:0] exp_vec);
        exp_q.push_back(exp_vec);
        IACK = 1'b1;
        @(negedge CLK);
        IACK = 1'b0;
    endtask

    task automatic chk_irq(input string name, input logic exp);
        check(name, {7'd0, IRQ_N}, {7'd0, exp});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; IRQ_SRC = '0; REG_WE = 1'b0; REG_SEL = '0; DAT_I = '0; IACK = 1'b0;
        cycle(); cycle();
        RST = 1'b0;
        for (int s = 0; s < 9; s++) rd("reset_reg", 4'(s), 8'h00);
        chk_irq("reset_irq_n", 1'b1);
        check("reset_vec_o", VEC_O, 8'h00);
        check("reset_vec_valid", {7'd0, VEC_VALID}, 8'h00);
        wr(4'd9, 8'hFF);
        rd("unmapped_sel9", 4'd9, 8'h00);
        rd("unmapped_no_side_effect", 4'd8, 8'h00);

        // 1. enable, pend, acknowledge
        wr(4'd1, 8'h20); wr(4'd7, 8'h20); wr(4'd8, 8'h40);
        pulse(16'h0020);
        rd("t1_iprb", 4'd3, 8'h20);
        chk_irq("t1_irq_latency", 1'b1);
        cycle();
        chk_irq("t1_irq_assert", 1'b0);
        ack(8'h45);
        rd("t1_iprb_clr", 4'd3, 8'h00);
        rd("t1_isrb", 4'd5, 8'h00);
        chk_irq("t1_irq_hold", 1'b0);
        cycle();
        chk_irq("t1_irq_deassert", 1'b1);

        // 2. priority and in-service nesting
        wr(4'd8, 8'h48); wr(4'd0, 8'h20); wr(4'd6, 8'h20);
        pulse(16'h2020);
        cycle();
        chk_irq("t2_irq", 1'b0);
        ack(8'h4D);
        rd("t2_isra", 4'd4, 8'h20);
        rd("t2_iprb", 4'd3, 8'h20);
        rd("t2_ipra", 4'd2, 8'h00);
        cycle();
        chk_irq("t2_irq_blocked", 1'b1);
        wr(4'd4, 8'h00);
        cycle();
        chk_irq("t2_irq_after_eoi", 1'b0);
        ack(8'h45);
        rd("t2_isrb", 4'd5, 8'h20);
        wr(4'd8, 8'h40);
        rd("t2_s_clear_isrb", 4'd5, 8'h00);

        // 3. mask and disable
        wr(4'd0, 8'h00); wr(4'd6, 8'h00); wr(4'd1, 8'h01); wr(4'd7, 8'h00);
        pulse(16'h0001);
        rd("t3_iprb_masked", 4'd3, 8'h01);
        cycle();
        chk_irq("t3_irq_masked", 1'b1);
        wr(4'd7, 8'h01);
        cycle();
        chk_irq("t3_irq_unmasked", 1'b0);
        wr(4'd1, 8'h00);
        rd("t3_iprb_disabled", 4'd3, 8'h00);
        cycle();
        chk_irq("t3_irq_disabled", 1'b1);
        pulse(16'h0001);
        rd("t3_iprb_ignored", 4'd3, 8'h00);

        // 4. same-cycle conflicts
        wr(4'd1, 8'h04); wr(4'd7, 8'h04);
        IRQ_SRC = 16'h0004;
        wr(4'd3, 8'h00);
        IRQ_SRC = '0;
        rd("t4_set_beats_wr_clr", 4'd3, 8'h04);
        IRQ_SRC = 16'h0004;
        ack(8'h42);
        IRQ_SRC = '0;
        rd("t4_set_beats_ack_clr", 4'd3, 8'h04);
        rd("t4_isrb_auto_eoi", 4'd5, 8'h00);
        wr(4'd3, 8'h00);
        rd("t4_iprb_wr_clr", 4'd3, 8'h00);
        IRQ_SRC = 16'h0004;
        wr(4'd1, 8'h00);
        IRQ_SRC = '0;
        rd("t4_disable_beats_set", 4'd3, 8'h00);

        // 5. spurious acknowledge
        ack(8'h18);
        rd("t5_iprb", 4'd3, 8'h00);
        rd("t5_isrb", 4'd5, 8'h00);
        rd("t5_imrb", 4'd7, 8'h04);
        rd("t5_vr", 4'd8, 8'h40);

        // 6. reset mid-service
        wr(4'd8, 8'h48); wr(4'd0, 8'h01); wr(4'd6, 8'h01);
        pulse(16'h0100);
        ack(8'h48);
        wr(4'd1, 8'h10);
        pulse(16'h0010);
        rd("t6_isra", 4'd4, 8'h01);
        rd("t6_iprb", 4'd3, 8'h10);
        RST = 1'b1; IACK = 1'b1;
        cycle();
        RST = 1'b0; IACK = 1'b0;
        for (int s = 0; s < 9; s++) rd("t6_reg_cleared", 4'(s), 8'h00);
        chk_irq("t6_irq_n", 1'b1);
        check("t6_vec_valid", {7'd0, VEC_VALID}, 8'h00);
        cycle(); cycle();

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL missing_vec: got %0d outstanding expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
